mac_acc_8: RTL and testbench
============================

Name: mac_acc_8

Overview:
- Sequential multiply-accumulate stage built around the existing 8x8 combinational array multiplier (arr_mul_8, instantiated internally).
- Accepts a burst of N_TERMS operand pairs over a valid/ready handshake, registers each 16-bit product, and accumulates the products into an ACC_W-bit sum.
- Presents the final dot-product to the downstream consumer with a valid/ready handshake.
- Used wherever the datapath needs 8-bit dot products, e.g. filter taps or vector engines.

Parameters:
- ACC_W, 24, accumulator and result width; must be >= 16.
- N_TERMS, 4, operand pairs per burst; must be >= 1.

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begins a burst; sampled only in IDLE.
- in_valid  input  1  operand pair A/B is valid.
- in_ready  output  1  block can accept an operand pair.
- A  input  8  unsigned multiplicand.
- B  input  8  unsigned multiplier.
- acc_out  output  ACC_W  accumulated result; stable while out_valid=1.
- out_valid  output  1  acc_out holds the final burst result.
- out_ready  input  1  consumer accepts the result.
- busy  output  1  high in every state except IDLE.
- overflow  output  1  sticky flag: the burst's true sum exceeded 2^ACC_W-1.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=IDLE, acc_out=0, count=0, p_reg=0, p_vld=0, in_ready=0, out_valid=0, busy=0, overflow=0.
- Reset asserted mid-burst aborts the burst immediately. No partial result is ever presented.
- All arithmetic is unsigned.
- Products are 16 bits from arr_mul_8 on the captured operands, zero-extended to ACC_W before addition.
- States: IDLE, ACCUM, DRAIN, DONE.
- IDLE:
  - in_ready=0.
  - start=1 at an edge -> acc_out<=0, count<=0, overflow<=0, p_vld<=0, next state ACCUM.
- ACCUM:
  - in_ready=1.
  - Transfer = in_valid & in_ready at a rising edge. On a transfer: p_reg<=A*B, p_vld<=1, count<=count+1.
  - No transfer -> p_vld<=0. Stalls (in_valid=0) of any length are legal.
  - Every edge where p_vld=1: acc_out<=acc_out+p_reg. This overlaps with the next transfer, giving one product per cycle throughput.
  - Transfer when count==N_TERMS-1 -> next state DRAIN.
- DRAIN:
  - in_ready=0.
  - Adds the last p_reg, clears p_vld, next state DONE.
- DONE:
  - out_valid=1, acc_out held.
  - out_ready=1 at an edge -> out_valid<=0, next state IDLE.
- Latency:
  - The product of a pair transferred at edge e is in acc_out after edge e+1.
  - out_valid rises after the edge following the last transfer.
  - Minimum burst is N_TERMS+2 cycles from start to out_valid.
- Ignored inputs:
  - start outside IDLE is ignored, including start together with out_ready in DONE.
  - in_valid outside ACCUM is ignored; A/B are don't-care.
- Overflow: the carry out of the ACC_W-bit add sets overflow. overflow is cleared only by start or rst.
- Default accumulation wraps modulo 2^ACC_W.

Optional Feature:
- Macro: MAC_ACC_SATURATE_EN.
- Defined: an add that would carry out clamps acc_out to 2^ACC_W-1. Subsequent adds in the same burst stay clamped. overflow sets as above.
- Undefined: acc_out wraps modulo 2^ACC_W. overflow still sets on carry out.

Test Plan:
- Basic burst (defaults): start, then pairs (2,3),(5,6),(255,1),(170,85) back-to-back -> out_valid two edges after the 4th transfer, acc_out=14741 (0x003995), overflow=0.
- Stall handling: same pairs with in_valid low for 3 cycles between pairs 2 and 3 -> same result 14741. in_ready stays 1 during the stall. No extra accumulation.
- Output backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid and acc_out=14741 held. start pulsed during DONE ignored. out_ready=1 -> IDLE, busy=0.
- Overflow (ACC_W=16): four pairs (255,255).
  - Without macro: acc_out=63492 (0xF804), overflow=1.
  - With MAC_ACC_SATURATE_EN: acc_out=0xFFFF, overflow=1.
- Reset mid-burst: assert rst asynchronously after 2 transfers -> all outputs 0 immediately, state IDLE. A new burst with zeros operands -> acc_out=0. A burst of (0,255)x4 -> 0.
- N_TERMS=1: start, single pair (255,255) -> acc_out=65025 after DRAIN. in_ready is 1 for exactly the transfer cycle.

Source files
------------

// File: rtl/mac_acc_8.sv
// rtl/mac_acc_8.sv - burst multiply-accumulate over arr_mul_8 with valid/ready handshakes
// Define MAC_ACC_SATURATE_EN to clamp the accumulator at 2^ACC_W-1 instead of wrapping.

module arr_mul_8 (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);

  // Shift-and-add of the partial-product rows.
  always_comb begin
    p = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p + ({8'b0, a} << i);
    end
  end

endmodule

module mac_acc_8 #(
  parameter int ACC_W   = 24,
  parameter int N_TERMS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       A,
  input  logic [7:0]       B,
  output logic [ACC_W-1:0] acc_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             overflow
);

  localparam int CW = $clog2(N_TERMS + 1);

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   count;
  logic [15:0]     p_reg;
  logic            p_vld;
  logic [15:0]     prod;
  logic [ACC_W:0]  sum;
  logic            transfer;
  logic            last;

  arr_mul_8 u_mul (
    .a (A),
    .b (B),
    .p (prod)
  );

  assign sum      = {1'b0, acc_out} + {{(ACC_W - 15){1'b0}}, p_reg};
  assign transfer = in_valid & in_ready;
  assign last     = transfer && (count == CW'(N_TERMS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nx = ACCUM;
      end
      ACCUM: begin
        in_ready = 1'b1;
        if (last) state_nx = DRAIN;
      end
      DRAIN: state_nx = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // The add of the previous product overlaps the capture of the next one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_out  <= '0;
      count    <= '0;
      p_reg    <= '0;
      p_vld    <= 1'b0;
      overflow <= 1'b0;
    end else if (state == IDLE && start) begin
      acc_out  <= '0;
      count    <= '0;
      p_vld    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (p_vld) begin
        if (sum[ACC_W]) overflow <= 1'b1;
`ifdef MAC_ACC_SATURATE_EN
        acc_out <= sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
        acc_out <= sum[ACC_W-1:0];
`endif
      end
      if (state == ACCUM) begin
        p_vld <= transfer;
        if (transfer) begin
          p_reg <= prod;
          count <= count + CW'(1);
        end
      end else begin
        p_vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mac_acc_8.sv
// tb/tb_mac_acc_8.sv - directed bursts on default, ACC_W=16 and N_TERMS=1 instances

module tb_mac_acc_8;

  typedef struct {
    int              dut;
    int              n;
    logic [3:0][7:0] a;
    logic [3:0][7:0] b;
    int              stall_after;
    int              stall_len;
    int              hold;
    logic [23:0]     exp_acc;
    logic            exp_ovf;
  } burst_t;

  logic clk = 1'b0;
  logic rst;
  logic        start_s     [3];
  logic        in_valid_s  [3];
  logic        out_ready_s [3];
  logic [7:0]  a_s         [3];
  logic [7:0]  b_s         [3];
  logic        in_ready_s  [3];
  logic        out_valid_s [3];
  logic        busy_s      [3];
  logic        ovf_s       [3];
  logic [23:0] acc_s       [3];
  logic [23:0] acc0, acc2;
  logic [15:0] acc1;

  int nchk  = 0;
  int nfail = 0;
  burst_t tbl [8];

  always #5 clk = ~clk;

  mac_acc_8 u_dut0 (
    .clk(clk), .rst(rst), .start(start_s[0]), .in_valid(in_valid_s[0]),
    .in_ready(in_ready_s[0]), .A(a_s[0]), .B(b_s[0]), .acc_out(acc0),
    .out_valid(out_valid_s[0]), .out_ready(out_ready_s[0]), .busy(busy_s[0]),
    .overflow(ovf_s[0])
  );

  mac_acc_8 #(.ACC_W(16)) u_dut1 (
    .clk(clk), .rst(rst), .start(start_s[1]), .in_valid(in_valid_s[1]),
    .in_ready(in_ready_s[1]), .A(a_s[1]), .B(b_s[1]), .acc_out(acc1),
    .out_valid(out_valid_s[1]), .out_ready(out_ready_s[1]), .busy(busy_s[1]),
    .overflow(ovf_s[1])
  );

  mac_acc_8 #(.N_TERMS(1)) u_dut2 (
    .clk(clk), .rst(rst), .start(start_s[2]), .in_valid(in_valid_s[2]),
    .in_ready(in_ready_s[2]), .A(a_s[2]), .B(b_s[2]), .acc_out(acc2),
    .out_valid(out_valid_s[2]), .out_ready(out_ready_s[2]), .busy(busy_s[2]),
    .overflow(ovf_s[2])
  );

  always_comb begin
    acc_s[0] = acc0;
    acc_s[1] = {8'b0, acc1};
    acc_s[2] = acc2;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_burst(input burst_t v);
    int d;
    logic [23:0] psum;
    d    = v.dut;
    psum = '0;
    start_s[d] = 1'b1;
    tick();
    start_s[d] = 1'b0;
    chk("busy_after_start", busy_s[d], 1);
    for (int i = 0; i < v.n; i++) begin
      chk("in_ready_accum", in_ready_s[d], 1);
      a_s[d] = v.a[i];
      b_s[d] = v.b[i];
      in_valid_s[d] = 1'b1;
      tick();
      in_valid_s[d] = 1'b0;
      a_s[d] = 8'hff;
      b_s[d] = 8'hff;
      psum = psum + 24'(v.a[i]) * 24'(v.b[i]);
      if (i == v.stall_after) begin
        for (int j = 0; j < v.stall_len; j++) begin
          tick();
          chk("in_ready_stall", in_ready_s[d], 1);
          chk("acc_stall", acc_s[d], psum);
        end
      end
    end
    chk("in_ready_drain", in_ready_s[d], 0);
    chk("out_valid_drain", out_valid_s[d], 0);
    tick();
    chk("out_valid_done", out_valid_s[d], 1);
    chk("acc_done", acc_s[d], v.exp_acc);
    chk("overflow_done", ovf_s[d], v.exp_ovf);
    for (int h = 0; h < v.hold; h++) begin
      start_s[d] = (h == 2);
      tick();
      start_s[d] = 1'b0;
      chk("out_valid_hold", out_valid_s[d], 1);
      chk("acc_hold", acc_s[d], v.exp_acc);
    end
    out_ready_s[d] = 1'b1;
    start_s[d] = (v.hold > 0);
    tick();
    out_ready_s[d] = 1'b0;
    start_s[d] = 1'b0;
    chk("out_valid_release", out_valid_s[d], 0);
    chk("busy_release", busy_s[d], 0);
  endtask

  initial begin
    logic [3:0][7:0] ba, bb, ff, zz, z255;
    ba   = {8'd170, 8'd255, 8'd5, 8'd2};
    bb   = {8'd85, 8'd1, 8'd6, 8'd3};
    ff   = {8'd255, 8'd255, 8'd255, 8'd255};
    zz   = '0;
    z255 = {8'd255, 8'd255, 8'd255, 8'd255};

    tbl[0] = '{dut:0, n:4, a:ba, b:bb, stall_after:-1, stall_len:0, hold:0, exp_acc:24'd14741, exp_ovf:1'b0};
    tbl[1] = '{dut:0, n:4, a:ba, b:bb, stall_after:1, stall_len:3, hold:0, exp_acc:24'd14741, exp_ovf:1'b0};
    tbl[2] = '{dut:0, n:4, a:ba, b:bb, stall_after:-1, stall_len:0, hold:5, exp_acc:24'd14741, exp_ovf:1'b0};
`ifdef MAC_ACC_SATURATE_EN
    tbl[3] = '{dut:1, n:4, a:ff, b:ff, stall_after:-1, stall_len:0, hold:0, exp_acc:24'h00ffff, exp_ovf:1'b1};
`else
    tbl[3] = '{dut:1, n:4, a:ff, b:ff, stall_after:-1, stall_len:0, hold:0, exp_acc:24'd63492, exp_ovf:1'b1};
`endif
    tbl[4] = '{dut:1, n:4, a:ba, b:bb, stall_after:-1, stall_len:0, hold:0, exp_acc:24'd14741, exp_ovf:1'b0};
    tbl[5] = '{dut:2, n:1, a:ff, b:ff, stall_after:-1, stall_len:0, hold:0, exp_acc:24'd65025, exp_ovf:1'b0};
    tbl[6] = '{dut:0, n:4, a:zz, b:zz, stall_after:-1, stall_len:0, hold:0, exp_acc:24'd0, exp_ovf:1'b0};
    tbl[7] = '{dut:0, n:4, a:zz, b:z255, stall_after:-1, stall_len:0, hold:0, exp_acc:24'd0, exp_ovf:1'b0};

    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      start_s[k] = 1'b0; in_valid_s[k] = 1'b0; out_ready_s[k] = 1'b0;
      a_s[k] = 8'h0; b_s[k] = 8'h0;
    end
    tick();
    tick();
    for (int k = 0; k < 3; k++) begin
      chk("rst_acc", acc_s[k], 0);
      chk("rst_in_ready", in_ready_s[k], 0);
      chk("rst_out_valid", out_valid_s[k], 0);
      chk("rst_busy", busy_s[k], 0);
      chk("rst_overflow", ovf_s[k], 0);
    end
    rst = 1'b0;
    tick();

    for (int t = 0; t < 6; t++) run_burst(tbl[t]);

    // Abort a burst with an asynchronous reset after two transfers.
    start_s[0] = 1'b1;
    tick();
    start_s[0] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      a_s[0] = ba[i];
      b_s[0] = bb[i];
      in_valid_s[0] = 1'b1;
      tick();
    end
    in_valid_s[0] = 1'b0;
    chk("pre_abort_acc", acc_s[0], 6);
    chk("pre_abort_busy", busy_s[0], 1);
    #2 rst = 1'b1;
    #1;
    chk("abort_acc", acc_s[0], 0);
    chk("abort_in_ready", in_ready_s[0], 0);
    chk("abort_out_valid", out_valid_s[0], 0);
    chk("abort_busy", busy_s[0], 0);
    chk("abort_overflow", ovf_s[0], 0);
    tick();
    rst = 1'b0;
    tick();
    chk("abort_idle_out_valid", out_valid_s[0], 0);

    for (int t = 6; t < 8; t++) run_burst(tbl[t]);

    $display("== %0d vectors applied, %0d miscompares ==", nchk, nfail);
    $finish;
  end

endmodule
